// File: rtl/adam_axil_ram_ws.sv
// adam_axil_ram_ws: AXI-Lite slave RAM with configurable read latency (wait states),
// round-robin read/write arbitration, byte strobes and a pause request/acknowledge pair.
// Only one transaction is in flight at a time.
//
// Optional feature macro: ADAM_AXIL_RAM_WS_ERR_EN
//   defined   - addresses >= SIZE answer SLVERR; writes are dropped, reads return zero.
//   undefined - no range check; addresses wrap modulo SIZE and every response is OKAY.

module adam_axil_ram_ws #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SIZE         = 4096,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    pause_req,
  output logic                    pause_ack,

  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic [2:0]              aw_prot,
  input  logic                    aw_valid,
  output logic                    aw_ready,

  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_valid,
  output logic                    w_ready,

  output logic [1:0]              b_resp,
  output logic                    b_valid,
  input  logic                    b_ready,

  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic [2:0]              ar_prot,
  input  logic                    ar_valid,
  output logic                    ar_ready,

  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_valid,
  input  logic                    r_ready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned Words      = SIZE / STRB_WIDTH;
  localparam int unsigned OffW       = $clog2(STRB_WIDTH);
  localparam int unsigned IdxW       = (Words > 1) ? $clog2(Words) : 1;

  // Cycles spent in StReadWait are READ_LATENCY-1; the counter runs down to zero.
  localparam logic [3:0] LatInit = 4'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    StPaused,
    StIdle,
    StWriteResp,
    StReadWait,
    StReadResp
  } state_e;

  typedef enum logic {
    RrRead,
    RrWrite
  } rr_e;

  state_e                  state_q, state_d;
  rr_e                     rr_last_q, rr_last_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    rd_err_q;
  logic [1:0]              b_resp_q;
  logic [1:0]              r_resp_q;
  logic [DATA_WIDTH-1:0]   r_data_q;

  logic [DATA_WIDTH-1:0]   mem [Words];

  logic                    wr_cand, rd_cand;
  logic                    wr_acc, rd_acc;
  logic                    aw_err, ar_err;
  logic                    load_r;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_err;
  logic [IdxW-1:0]         wr_idx, rd_idx;

  // Protection bits carry no meaning for this RAM.
  logic unused_prot;
  assign unused_prot = ^{aw_prot, ar_prot};

  // Word index from a byte address: drop the byte offset, wrap modulo the array depth.
  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] w;
    w = (addr >> OffW) & ADDR_WIDTH'(Words - 1);
    return w[IdxW-1:0];
  endfunction

`ifdef ADAM_AXIL_RAM_WS_ERR_EN
  assign aw_err = (64'(aw_addr) >= 64'(SIZE));
  assign ar_err = (64'(ar_addr) >= 64'(SIZE));
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign wr_cand = aw_valid && w_valid;
  assign rd_cand = ar_valid;

  // Next state, accept strobes and arbitration.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    ar_ready  = 1'b0;
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    unique case (state_q)
      StPaused: begin
        if (!pause_req) state_d = StIdle;
      end
      StIdle: begin
        // Pause wins over new work so a quiesce request is never starved.
        if (pause_req) begin
          state_d = StPaused;
        end else if (wr_cand && (!rd_cand || rr_last_q == RrRead)) begin
          aw_ready  = 1'b1;
          w_ready   = 1'b1;
          wr_acc    = 1'b1;
          rr_last_d = RrWrite;
          state_d   = StWriteResp;
        end else if (rd_cand) begin
          ar_ready  = 1'b1;
          rd_acc    = 1'b1;
          rr_last_d = RrRead;
          if (READ_LATENCY <= 1) begin
            state_d = StReadResp;
          end else begin
            state_d = StReadWait;
            cnt_d   = LatInit;
          end
        end
      end
      StWriteResp: begin
        if (b_ready) state_d = pause_req ? StPaused : StIdle;
      end
      StReadWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StReadResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StReadResp: begin
        if (r_ready) state_d = pause_req ? StPaused : StIdle;
      end
      default: state_d = StPaused;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StPaused;
      rr_last_q <= RrRead;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  // With no wait states the read is served straight from the AR channel.
  assign rd_addr = (state_q == StIdle) ? ar_addr : rd_addr_q;
  assign rd_err  = (state_q == StIdle) ? ar_err  : rd_err_q;
  assign rd_idx  = word_idx(rd_addr);
  assign wr_idx  = word_idx(aw_addr);
  assign load_r  = (state_d == StReadResp) && (state_q != StReadResp);

  // Response registers; r_data/r_resp only load on entry to StReadResp, so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q <= '0;
      rd_err_q  <= 1'b0;
      b_resp_q  <= RespOkay;
      r_resp_q  <= RespOkay;
      r_data_q  <= '0;
    end else begin
      if (wr_acc) b_resp_q <= aw_err ? RespSlvErr : RespOkay;
      if (rd_acc) begin
        rd_addr_q <= ar_addr;
        rd_err_q  <= ar_err;
      end
      if (load_r) begin
        r_data_q <= rd_err ? '0 : mem[rd_idx];
        r_resp_q <= rd_err ? RespSlvErr : RespOkay;
      end
    end
  end

  // Storage array, byte-strobed writes, contents not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !aw_err) begin
      for (int i = 0; i < int'(STRB_WIDTH); i++) begin
        if (w_strb[i]) mem[wr_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  assign pause_ack = (state_q == StPaused);
  assign b_valid   = (state_q == StWriteResp);
  assign r_valid   = (state_q == StReadResp);
  assign b_resp    = b_resp_q;
  assign r_resp    = r_resp_q;
  assign r_data    = r_data_q;

endmodule

// File: tb/tb_adam_axil_ram_ws.sv
// Bench for adam_axil_ram_ws (SIZE=4096, READ_LATENCY=4): directed scenarios plus randomized
// write/read/concurrent traffic checked against a word-array reference model.

module tb_adam_axil_ram_ws;

  localparam int unsigned Lat  = 4;
  localparam int unsigned Size = 4096;
`ifdef ADAM_AXIL_RAM_WS_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pause_req;
  logic        pause_ack;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mdl [Size/4];
  bit          last_w;  // model: last served transaction was a write

  adam_axil_ram_ws #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .SIZE        (Size),
    .READ_LATENCY(Lat)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pause_req(pause_req),
    .pause_ack(pause_ack),
    .aw_addr  (aw_addr),
    .aw_prot  (aw_prot),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .w_data   (w_data),
    .w_strb   (w_strb),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .b_resp   (b_resp),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .ar_addr  (ar_addr),
    .ar_prot  (ar_prot),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .r_data   (r_data),
    .r_resp   (r_resp),
    .r_valid  (r_valid),
    .r_ready  (r_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
    int idx;
    if (ErrEn && a >= Size) begin
      resp = 2'b10;
    end else begin
      idx = int'((a % Size) / 4);
      for (int i = 0; i < 4; i++) if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
      resp = 2'b00;
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    if (ErrEn && a >= Size) begin
      d    = 32'h0;
      resp = 2'b10;
    end else begin
      d    = mdl[int'((a % Size) / 4)];
      resp = 2'b00;
    end
  endtask

  // Offer a write, a read or both at once and see every offered transaction to completion.
  task automatic run_step(input bit want_w, input bit want_r, input logic [31:0] wa,
                          input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ra,
                          input int rdelay);
    bit          pend_w, pend_r, served_w;
    int          guard, n;
    logic [31:0] exp_d, held;
    logic [1:0]  exp_resp;
    pend_w = want_w;
    pend_r = want_r;
    @(negedge clk);
    aw_addr  = wa;
    w_data   = wd;
    w_strb   = ws;
    ar_addr  = ra;
    aw_valid = want_w;
    w_valid  = want_w;
    ar_valid = want_r;
    while (pend_w || pend_r) begin
      #1;
      guard = 0;
      while (!(aw_ready && w_ready) && !ar_ready && guard < 50) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 50) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        ar_valid = 1'b0;
        return;
      end
      check_eq("single_grant", 32'((aw_ready || w_ready) && ar_ready), 32'd0);
      served_w = aw_ready && w_ready;
      check_eq("grant_offered", 32'(served_w ? pend_w : pend_r), 32'd1);
      if (pend_w && pend_r) check_eq("rr_order", 32'(served_w), 32'(!last_w));
      last_w = served_w;
      if (served_w) model_write(wa, wd, ws, exp_resp);
      else          model_read(ra, exp_d, exp_resp);
      @(posedge clk);
      #1;
      if (served_w) begin
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        pend_w   = 1'b0;
        check_eq("b_valid", 32'(b_valid), 32'd1);
        check_eq("b_resp", 32'(b_resp), 32'(exp_resp));
        @(negedge clk);
        b_ready = 1'b1;
        @(posedge clk);
        #1;
        b_ready = 1'b0;
      end else begin
        ar_valid = 1'b0;
        pend_r   = 1'b0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!r_valid && n < 40);
        check_eq("r_latency", 32'(n), 32'(Lat));
        check_eq("r_data", r_data, exp_d);
        check_eq("r_resp", 32'(r_resp), 32'(exp_resp));
        held = r_data;
        repeat (rdelay) begin
          @(negedge clk);
          check_eq("r_valid_hold", 32'(r_valid), 32'd1);
          check_eq("r_data_hold", r_data, held);
        end
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int          guard, kind;
    rst       = 1'b1;
    pause_req = 1'b0;
    aw_addr   = '0;
    aw_prot   = 3'd0;
    aw_valid  = 1'b0;
    w_data    = '0;
    w_strb    = '0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    ar_addr   = '0;
    ar_prot   = 3'd0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    last_w    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_pause_ack", 32'(pause_ack), 32'd1);
    check_eq("rst_valids", 32'({b_valid, r_valid}), 32'd0);
    check_eq("rst_readys", 32'({aw_ready, w_ready, ar_ready}), 32'd0);
    check_eq("rst_resps", 32'({b_resp, r_resp}), 32'd0);
    check_eq("rst_r_data", r_data, 32'd0);

    // Leaving pause one cycle after reset release
    rst = 1'b0;
    #1;
    check_eq("pause_ack_release", 32'(pause_ack), 32'd1);
    @(negedge clk);
    check_eq("pause_ack_fall", 32'(pause_ack), 32'd0);

    // Seed the words used by the rest of the run
    for (int i = 0; i < 16; i++) run_step(1'b1, 1'b0, 32'(i * 4), $urandom, 4'hF, 32'h0, 0);

    // Full write then byte-strobed merge
    run_step(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
    run_step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, 0);
    run_step(1'b1, 1'b0, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 0);
    run_step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h10, 3);
    check_eq("merge_model", mdl[4], 32'hDEADBEAA);

    // Concurrent offers: alternation W,R,W,R...
    for (int i = 0; i < 4; i++) begin
      run_step(1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, 32'((i + 4) * 4), 0);
    end

    // Out-of-range read
    run_step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h2000, 1);

    // Pause raised while a read is waiting
    @(negedge clk);
    ar_addr  = 32'h10;
    ar_valid = 1'b1;
    #1;
    guard = 0;
    while (!ar_ready && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check_eq("pause_rd_accept", 32'(ar_ready), 32'd1);
    last_w = 1'b0;
    model_read(32'h10, d, kind[1:0]);
    @(posedge clk);
    #1;
    ar_valid  = 1'b0;
    pause_req = 1'b1;
    guard = 0;
    while (!r_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("pause_rd_data", r_data, d);
    check_eq("pause_ack_busy", 32'(pause_ack), 32'd0);
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
    @(negedge clk);
    check_eq("pause_ack_after", 32'(pause_ack), 32'd1);
    ar_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("paused_no_ar", 32'(ar_ready), 32'd0);
    end
    ar_valid  = 1'b0;
    pause_req = 1'b0;
    @(negedge clk);
    check_eq("unpause_ack", 32'(pause_ack), 32'd0);

    // Reset in the middle of a waited read drops it
    @(negedge clk);
    ar_addr  = 32'h14;
    ar_valid = 1'b1;
    @(negedge clk);
    ar_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_eq("midrst_r_valid", 32'(r_valid), 32'd0);
    check_eq("midrst_pause_ack", 32'(pause_ack), 32'd1);
    check_eq("midrst_r_data", r_data, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    last_w = 1'b0;
    repeat (Lat + 1) begin
      @(negedge clk);
      check_eq("midrst_no_resp", 32'(r_valid), 32'd0);
    end

    // Randomized traffic, including out-of-range and unaligned addresses
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a + 32'h1000;
      d = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 4) == 0) d = d + 32'h3000;
      run_step(kind != 1, kind != 0, a, $urandom, 4'($urandom_range(0, 15)), d,
               int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
